// File: rtl/seg_time_display_pkg.sv
// Shared constants for the HH.MM.SS seven-segment display: font, digit positions,
// conversion FSM encoding and the font lookup.
package seg_time_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DD_ITERS   = 6;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left off here and applied per digit.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
  localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
  localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
  localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
  localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
  localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

  function automatic logic [7:0] seg_font(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_font = SEG_0;
      4'd1:    seg_font = SEG_1;
      4'd2:    seg_font = SEG_2;
      4'd3:    seg_font = SEG_3;
      4'd4:    seg_font = SEG_4;
      4'd5:    seg_font = SEG_5;
      4'd6:    seg_font = SEG_6;
      4'd7:    seg_font = SEG_7;
      4'd8:    seg_font = SEG_8;
      4'd9:    seg_font = SEG_9;
      default: seg_font = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_time_display_if.sv
// Link between the time counter (master) and the display driver (slave):
// binary time, scan tick, and the board-facing select/segment lines.
interface seg_time_display_if;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       flag_scan;
  logic [5:0] sel;
  logic [7:0] seg;

  modport master (output hour, min, sec, flag_scan, input  sel, seg);
  modport slave  (input  hour, min, sec, flag_scan, output sel, seg);
endinterface

// File: rtl/bin6_to_bcd_seq.sv
// Sequential double-dabble for a 6-bit value: loads on i_start, then one
// add-3/shift iteration per clock; o_done rises after the last iteration.
module bin6_to_bcd_seq
  import seg_time_display_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_start,
  input  logic [5:0] i_bin,
  output logic       o_done,
  output logic [7:0] o_bcd
);

  logic [5:0] r_bin;
  logic [7:0] r_bcd;
  logic [2:0] r_cnt;
  logic       r_done;
  logic [7:0] w_adj;

  // NOTE: defaulting every comb output first keeps all paths assigned, so no latch.
  always_comb begin
    w_adj = r_bcd;
    if (r_bcd[3:0] >= 4'd5) w_adj[3:0] = r_bcd[3:0] + 4'd3;
    if (r_bcd[7:4] >= 4'd5) w_adj[7:4] = r_bcd[7:4] + 4'd3;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= 3'(DD_ITERS);
      r_done <= 1'b0;
    end else if (r_cnt != 3'd0) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt - 3'd1;
      r_done         <= (r_cnt == 3'd1);
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_time_display.sv
// Six-digit multiplexed common-anode display for HH.MM.SS: converts a captured
// time into a held BCD image, then scans one digit per tick with de-ghost blanking.
module seg_time_display
  import seg_time_display_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES  = 4,
  parameter bit          HOUR_LZ_BLANK = 1'b1,
  parameter bit          DP_BLINK      = 1'b1
) (
  input logic               clk,
  input logic               rstn,
  seg_time_display_if.slave bus
);

  conv_state_t r_state, w_next_state;
  logic        w_start, w_commit;
  logic        w_done_hour, w_done_min, w_done_sec;
  logic [7:0]  w_bcd_hour, w_bcd_min, w_bcd_sec;

  logic [NUM_DIGITS-1:0][3:0] r_image;
  logic [2:0]  r_idx;
  logic [3:0]  r_blank;
  logic        r_scan_on;
  logic [3:0]  w_digit;
  logic [5:0]  w_sel, r_sel;
  logic [7:0]  w_seg, r_seg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (bus.flag_scan) w_next_state = ST_SHIFT;
      ST_SHIFT:  if (w_done_hour && w_done_min && w_done_sec) w_next_state = ST_COMMIT;
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start  = (r_state == ST_IDLE) && bus.flag_scan;
    w_commit = (r_state == ST_COMMIT);
  end

  // The converters' load registers are the input snapshot.
  bin6_to_bcd_seq u_bcd_hour (.clk(clk), .rstn(rstn), .i_start(w_start),
    .i_bin({1'b0, bus.hour}), .o_done(w_done_hour), .o_bcd(w_bcd_hour));
  bin6_to_bcd_seq u_bcd_min  (.clk(clk), .rstn(rstn), .i_start(w_start),
    .i_bin(bus.min), .o_done(w_done_min), .o_bcd(w_bcd_min));
  bin6_to_bcd_seq u_bcd_sec  (.clk(clk), .rstn(rstn), .i_start(w_start),
    .i_bin(bus.sec), .o_done(w_done_sec), .o_bcd(w_bcd_sec));

  // NOTE: the image is a tiny register file that must read as zeros after reset, so unlike a RAM it is reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_image <= '0;
    else if (w_commit) r_image <= {w_bcd_hour, w_bcd_min, w_bcd_sec};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx     <= DIG_SEC_ONES;
      r_blank   <= '0;
      r_scan_on <= 1'b0;
    end else if (bus.flag_scan) begin
      r_idx     <= (r_idx == DIG_HOUR_TENS) ? DIG_SEC_ONES : r_idx + 3'd1;
      r_blank   <= 4'(BLANK_CYCLES);
      r_scan_on <= 1'b1;
    end else if (r_blank != 4'd0) begin
      r_blank <= r_blank - 4'd1;
    end
  end

  // Seconds-ones parity equals sec[0] of the committed snapshot, so it drives the dot blink.
  always_comb begin
    w_digit = r_image[r_idx];
    w_sel   = '1;
    w_seg   = SEG_BLANK;
    if (r_scan_on && (r_blank == 4'd0)) begin
      w_sel[r_idx] = 1'b0;
      w_seg        = seg_font(w_digit);
      if (HOUR_LZ_BLANK && (r_idx == DIG_HOUR_TENS) && (w_digit == 4'd0))
        w_seg = SEG_BLANK;
      if (((r_idx == DIG_HOUR_ONES) || (r_idx == DIG_MIN_ONES)) &&
          (!DP_BLINK || !r_image[DIG_SEC_ONES][0]))
        w_seg[7] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_sel <= w_sel;
      r_seg <= w_seg;
    end
  end

  assign bus.sel = r_sel;
  assign bus.seg = r_seg;

endmodule
